// File: rtl/ls_iso_seq_pkg.sv
// ---------------------------------------------------------------------------
// ls_iso_seq_pkg : states and output decode for the isolation sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ls_iso_seq_pkg;

  typedef enum logic [2:0] {
    ST_ON           = 3'd0,
    ST_ISO_SETUP    = 3'd1,
    ST_PWR_OFF_WAIT = 3'd2,
    ST_OFF          = 3'd3,
    ST_PWR_ON_WAIT  = 3'd4,
    ST_SETTLE       = 3'd5
  } state_e;

  // Output vector layout is {iso_en, pwr_sw_en}
  localparam int unsigned OUT_ISO_BIT = 1;
  localparam int unsigned OUT_SW_BIT  = 0;

  localparam logic [1:0] OUT_ON           = 2'b01;
  localparam logic [1:0] OUT_ISO_SETUP    = 2'b11;
  localparam logic [1:0] OUT_PWR_OFF_WAIT = 2'b10;
  localparam logic [1:0] OUT_OFF          = 2'b10;
  localparam logic [1:0] OUT_PWR_ON_WAIT  = 2'b11;
  localparam logic [1:0] OUT_SETTLE       = 2'b11;

  function automatic logic [1:0] out_decode(input state_e s);
    logic [1:0] v;
    case (s)
      ST_ON:           v = OUT_ON;
      ST_ISO_SETUP:    v = OUT_ISO_SETUP;
      ST_PWR_OFF_WAIT: v = OUT_PWR_OFF_WAIT;
      ST_OFF:          v = OUT_OFF;
      ST_PWR_ON_WAIT:  v = OUT_PWR_ON_WAIT;
      ST_SETTLE:       v = OUT_SETTLE;
      default:         v = OUT_OFF;
    endcase
    return v;
  endfunction

  function automatic logic is_stable(input state_e s);
    return (s == ST_ON) || (s == ST_OFF);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ls_iso_seq_timer.sv
// ---------------------------------------------------------------------------
// ls_iso_seq_timer : loadable down-counter with zero flag, saturates at 0
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ls_iso_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/ls_iso_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ls_iso_seq_ctrl : clamp/power-switch sequencer for one switchable domain
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ls_iso_seq_ctrl
  import ls_iso_seq_pkg::*;
#(
  parameter int unsigned ISO_SETUP_CYC   = 4,
  parameter int unsigned PWR_SETTLE_CYC  = 8,
  parameter int unsigned ACK_TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwr_dn_req_i,
  input  logic pwr_up_req_i,
  input  logic pwr_ack_i,
  output logic iso_en_o,
  output logic pwr_sw_en_o,
  output logic domain_on_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  localparam logic [CNT_W-1:0] ISO_LOAD    = CNT_W'(ISO_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(PWR_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LOAD    = CNT_W'(ACK_TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic [1:0]       out_vec;

  ls_iso_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_ON: begin
        if (pwr_dn_req_i) begin
          state_d  = ST_ISO_SETUP;
          tmr_load = 1'b1;
          tmr_val  = ISO_LOAD;
          err_d    = 1'b0;
        end
      end
      ST_ISO_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_PWR_OFF_WAIT;
          tmr_load = 1'b1;
          tmr_val  = ACK_LOAD;
        end
      end
      ST_PWR_OFF_WAIT: begin
        if (!pwr_ack_i) begin
          state_d = ST_OFF;
          done_d  = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_OFF;
          err_d   = 1'b1;
        end
      end
      ST_OFF: begin
        if (pwr_up_req_i) begin
          state_d  = ST_PWR_ON_WAIT;
          tmr_load = 1'b1;
          tmr_val  = ACK_LOAD;
          err_d    = 1'b0;
        end
      end
      ST_PWR_ON_WAIT: begin
        if (pwr_ack_i) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
        end else if (tmr_zero) begin
          state_d = ST_OFF;
          err_d   = 1'b1;
        end
      end
      ST_SETTLE: begin
        // Ack is deliberately not watched here; glitches during settle are ignored
        if (tmr_zero) begin
          state_d = ST_ON;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  assign out_vec     = out_decode(state_q);
  assign iso_en_o    = out_vec[OUT_ISO_BIT];
  assign pwr_sw_en_o = out_vec[OUT_SW_BIT];
  assign domain_on_o = (state_q == ST_ON);
  assign busy_o      = !is_stable(state_q);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ls_iso_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ls_iso_seq_ctrl : directed scenarios plus random run against a
// phase/elapsed-cycle reference model of the sequencer
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ls_iso_seq_ctrl;

  localparam int ISO    = 4;
  localparam int SETTLE = 8;
  localparam int ACK_TO = 64;

  // Reference model phases
  localparam int P_OFF = 0, P_UPW = 1, P_SET = 2, P_ON = 3, P_ISO = 4, P_DNW = 5;

  logic clk = 1'b0;
  logic rst, up, dn, ack;
  logic iso, sw, don, busy, done, err;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_ph, m_n;
  bit m_err, m_done;

  ls_iso_seq_ctrl #(
    .ISO_SETUP_CYC   (ISO),
    .PWR_SETTLE_CYC  (SETTLE),
    .ACK_TIMEOUT_CYC (ACK_TO),
    .CNT_W           (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pwr_dn_req_i (dn),
    .pwr_up_req_i (up),
    .pwr_ack_i    (ack),
    .iso_en_o     (iso),
    .pwr_sw_en_o  (sw),
    .domain_on_o  (don),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  // Model: m_n counts cycles completed in the current phase
  always @(posedge clk) begin
    if (rst) begin
      m_ph = P_OFF; m_n = 0; m_err = 0; m_done = 0;
    end else begin
      m_done = 0;
      m_n    = m_n + 1;
      case (m_ph)
        P_ON:  if (dn) begin m_ph = P_ISO; m_n = 0; m_err = 0; end
        P_ISO: if (m_n == ISO) begin m_ph = P_DNW; m_n = 0; end
        P_DNW: if (!ack) begin m_ph = P_OFF; m_n = 0; m_done = 1; end
               else if (m_n == ACK_TO) begin m_ph = P_OFF; m_n = 0; m_err = 1; end
        P_OFF: if (up) begin m_ph = P_UPW; m_n = 0; m_err = 0; end
        P_UPW: if (ack) begin m_ph = P_SET; m_n = 0; end
               else if (m_n == ACK_TO) begin m_ph = P_OFF; m_n = 0; m_err = 1; end
        P_SET: if (m_n == SETTLE) begin m_ph = P_ON; m_n = 0; m_done = 1; end
        default: m_ph = P_OFF;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_on(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (don) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1; up = 0; dn = 0; ack = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({iso, sw, don, busy, done, err} !== 6'b100000) begin
        n_fail++;
        $display("FAIL reset_state: got %b want 100000", {iso, sw, don, busy, done, err});
      end
    end
    rst = 0;
  endtask

  task automatic test_power_up();
    logic [4:0] exp;
    up = 1; ack = 0;
    for (int c = 1; c <= 14; c++) begin
      step();
      exp = {(c < 4 + SETTLE), 1'b1, (c >= 4 + SETTLE), (c < 4 + SETTLE), (c == 4 + SETTLE)};
      n_cmp++;
      if ({iso, sw, don, busy, done} !== exp) begin
        n_fail++;
        $display("FAIL power_up c%0d: got %b want %b", c, {iso, sw, don, busy, done}, exp);
      end
      if (c == 3) ack = 1;
      if (c == 4 + SETTLE) up = 0;
    end
  endtask

  task automatic test_power_down();
    logic [5:0] exp;
    ack = 0; dn = 1;
    for (int c = 1; c <= 8; c++) begin
      step();
      exp = {1'b1, (c <= ISO), 1'b0, (c <= ISO + 1), (c == ISO + 2), 1'b0};
      n_cmp++;
      if ({iso, sw, don, busy, done, err} !== exp) begin
        n_fail++;
        $display("FAIL power_down c%0d: got %b want %b", c, {iso, sw, don, busy, done, err}, exp);
      end
      if (c == 1) dn = 0;
    end
  endtask

  task automatic test_timeout_up();
    bit ok;
    up = 1; ack = 0;
    for (int c = 1; c <= ACK_TO + 1; c++) begin
      step();
      if (c == 1) up = 0;
      if (c <= ACK_TO) begin
        n_cmp++;
        if ({iso, sw, busy, done, err} !== 5'b11100) begin
          n_fail++;
          $display("FAIL timeout_up_wait c%0d: got %b want 11100", c, {iso, sw, busy, done, err});
        end
      end else begin
        n_cmp++;
        if ({iso, sw, don, busy, done, err} !== 6'b100001) begin
          n_fail++;
          $display("FAIL timeout_up_end: got %b want 100001", {iso, sw, don, busy, done, err});
        end
      end
    end
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    up = 1; ack = 1;
    step();
    n_cmp++;
    if ({sw, err} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_clear_on_up: got %b want 10", {sw, err});
    end
    up = 0;
    wait_on(SETTLE + 4, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_up_recover: got not-on want on");
    end
  endtask

  task automatic test_timeout_down();
    bit ok;
    bit saw_done = 0;
    ack = 1; dn = 1;
    for (int c = 1; c <= ISO + ACK_TO + 1; c++) begin
      step();
      if (c == 1) dn = 0;
      if (done) saw_done = 1;
    end
    n_cmp++;
    if ({iso, sw, don, busy, saw_done, err} !== 6'b100001) begin
      n_fail++;
      $display("FAIL timeout_down: got %b want 100001", {iso, sw, don, busy, saw_done, err});
    end
    up = 1;
    wait_on(SETTLE + 4, ok);
    up = 0;
    n_cmp++;
    if (!ok || err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_down_recover: got on=%b err=%b want on=1 err=0", ok, err);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    ack = 0; up = 1; dn = 1;
    for (int c = 1; c <= ISO + 3; c++) begin
      step();
      if (c == ISO + 2) begin
        n_cmp++;
        if ({iso, sw, don, busy, done} !== 5'b10001) begin
          n_fail++;
          $display("FAIL simul_off: got %b want 10001", {iso, sw, don, busy, done});
        end
      end
      if (c == ISO + 3) begin
        n_cmp++;
        if ({iso, sw, don, busy, done} !== 5'b11010) begin
          n_fail++;
          $display("FAIL simul_up_start: got %b want 11010", {iso, sw, don, busy, done});
        end
      end
    end
    dn = 0; ack = 1;
    wait_on(SETTLE + 4, ok);
    up = 0;
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL simul_recover: got not-on want on");
    end
  endtask

  task automatic test_reset_mid();
    rst = 1; up = 0; dn = 0; ack = 0;
    step();
    rst = 0; up = 1; ack = 1;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_cmp++;
      if ({iso, sw, busy, done} !== 4'b1110) begin
        n_fail++;
        $display("FAIL reset_mid_seq c%0d: got %b want 1110", c, {iso, sw, busy, done});
      end
    end
    rst = 1; up = 0;
    step();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({iso, sw, don, busy, done, err} !== 6'b100000) begin
        n_fail++;
        $display("FAIL reset_mid_after i%0d: got %b want 100000", i, {iso, sw, don, busy, done, err});
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [5:0] exp;
    logic prev_iso, prev_sw;
    rst = 1; up = 0; dn = 0; ack = 0;
    step();
    rst = 0;
    prev_iso = iso; prev_sw = sw;
    for (int i = 0; i < 4000; i++) begin
      up  = ($urandom_range(0, 9) < 3);
      dn  = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 5) == 0) ack = ~ack;
      rst = ($urandom_range(0, 599) == 0);
      step();
      exp = {(m_ph != P_ON),
             (m_ph == P_UPW || m_ph == P_SET || m_ph == P_ON || m_ph == P_ISO),
             (m_ph == P_ON),
             (m_ph != P_ON && m_ph != P_OFF),
             m_done, m_err};
      n_cmp++;
      if ({iso, sw, don, busy, done, err} !== exp) begin
        n_fail++;
        $display("FAIL random_model i%0d: got %b want %b", i, {iso, sw, don, busy, done, err}, exp);
      end
      n_cmp++;
      if ((!sw && !iso) || (!iso && !don) || (prev_iso && !iso && (prev_sw != sw))) begin
        n_fail++;
        $display("FAIL random_invariant i%0d: got iso=%b sw=%b on=%b want clamp held", i, iso, sw, don);
      end
      prev_iso = iso; prev_sw = sw;
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; up = 0; dn = 0; ack = 0;
    test_reset();
    test_power_up();
    test_power_down();
    test_timeout_up();
    test_timeout_down();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ls_iso_seq_ctrl.md
Name: ls_iso_seq_ctrl

Overview:
- Power-domain isolation sequencer for the level-shifter/isolation cells (EN-gated shifters: output H forced low while EN=1) at a switchable voltage-domain boundary.
- Orders the steps correctly: clamp before power-off; power-on, then settle, before unclamp. Handles power-switch acknowledge and timeout.
- Sits in the always-on domain, next to the power-switch controller. One instance per switchable domain.

Parameters:
- ISO_SETUP_CYC, 4: cycles the clamp is held before the power switch opens (≥1).
- PWR_SETTLE_CYC, 8: cycles after power-good ack before the clamp is released (≥1).
- ACK_TIMEOUT_CYC, 64: maximum cycles to wait for pwr_ack_i (≥1).
- CNT_W, 8: timer width; must hold max(ISO_SETUP_CYC, PWR_SETTLE_CYC, ACK_TIMEOUT_CYC).

Ports:
- clk_i  input  1  always-on clock.
- rst_i  input  1  one clock; reset is synchronous and active-high.
- pwr_dn_req_i  input  1  level request to power the domain down.
- pwr_up_req_i  input  1  level request to power the domain up.
- pwr_ack_i  input  1  power-switch status (1 = domain supply good, 0 = off).
- iso_en_o  output  1  drives EN of all boundary level shifters (1 = clamp outputs low).
- pwr_sw_en_o  output  1  power-switch enable (1 = domain powered).
- domain_on_o  output  1  high only in state ON.
- busy_o  output  1  high in any transitional state.
- done_o  output  1  one-cycle pulse when a sequence completes successfully.
- err_o  output  1  sticky ack-timeout flag.

Behaviour:
- Reset: state OFF, iso_en_o=1, pwr_sw_en_o=0, domain_on_o=0, busy_o=0, done_o=0, err_o=0, timer=0. Reset mid-sequence aborts to this state in the next cycle.
- All outputs are registered (Moore, decoded from state). A request sampled at edge t affects outputs from cycle t+1.
- States:
  - ON (iso=0, sw=1): if pwr_dn_req_i, go to ISO_SETUP and load timer with ISO_SETUP_CYC-1.
  - ISO_SETUP (iso=1, sw=1): count down; at timer==0, go to PWR_OFF_WAIT and load timer with ACK_TIMEOUT_CYC-1. Lasts exactly ISO_SETUP_CYC cycles.
  - PWR_OFF_WAIT (iso=1, sw=0):
    - pwr_ack_i==0: go to OFF and pulse done_o in the first OFF cycle.
    - Else at timer==0: set err_o and go to OFF with no done_o.
  - OFF (iso=1, sw=0): if pwr_up_req_i, go to PWR_ON_WAIT and load timer with ACK_TIMEOUT_CYC-1.
  - PWR_ON_WAIT (iso=1, sw=1):
    - pwr_ack_i==1: go to SETTLE and load timer with PWR_SETTLE_CYC-1.
    - Else at timer==0: set err_o and go to OFF (sw drops to 0, iso stays 1).
  - SETTLE (iso=1, sw=1): at timer==0, go to ON and pulse done_o in the first ON cycle.
- Invariant: iso_en_o is 1 whenever pwr_sw_en_o is 0, or whenever the state is anything other than ON. iso_en_o never falls in the same cycle pwr_sw_en_o changes.
- Requests in transitional states are ignored, not queued. A level request still high on returning to a stable state is honoured then.
- pwr_dn_req_i in OFF and pwr_up_req_i in ON are no-ops. If both requests are high, only the one that is meaningful in the current stable state acts.
- err_o is cleared when a new request is accepted (ON→ISO_SETUP or OFF→PWR_ON_WAIT), otherwise held.
- A glitch of pwr_ack_i during SETTLE is ignored. Ack monitoring happens only in the WAIT states.

Decomposition:
- Package ls_iso_seq_pkg holds:
  - the state enum (ON, ISO_SETUP, PWR_OFF_WAIT, OFF, PWR_ON_WAIT, SETTLE);
  - localparam output-decode constants.
- One natural sub-module: ls_iso_seq_timer, a loadable CNT_W down-counter with a zero flag, shared by all timed states.

Test Plan:
- Reset then up request (ISO_SETUP_CYC=4, PWR_SETTLE_CYC=8):
  - Stimulus: pwr_up_req_i=1 at edge 0; ack rises in cycle 3.
  - Response: sw=1 from cycle 1; SETTLE cycles 4–11; ON at cycle 12 with iso=0, done_o=1 for one cycle.
- Down from ON:
  - Stimulus: pwr_dn_req_i=1 at edge 0; ack=0 already.
  - Response: iso=1 at cycle 1; sw=0 at cycle 5; OFF and done_o at cycle 6.
- Ack timeout on power-up (ACK_TIMEOUT_CYC=64):
  - Stimulus: ack held 0.
  - Response: after 64 cycles in PWR_ON_WAIT, err_o=1, state OFF, sw=0, iso=1, no done_o. The next up request clears err_o.
- Simultaneous requests:
  - Stimulus: up+dn both high in ON.
  - Response: down sequence runs. Both stay high; when it returns to OFF, the up sequence starts the next cycle.
- Reset mid-sequence:
  - Stimulus: rst_i in SETTLE cycle 3.
  - Response: next cycle iso=1, sw=0, OFF, no done_o.
- Invariant check:
  - Stimulus: randomised requests and ack.
  - Response: the bench asserts every cycle that (!pwr_sw_en_o → iso_en_o) and that iso_en_o==0 only in ON.
